// File: rtl/frame_capture_pkg.sv
// Shared types and helpers for the frame capture buffer: FSM state encoding,
// raster/pixel widths and the RGB888 quantizer.
package frame_capture_pkg;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned RGB_W    = 24;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_ARM   = 2'd1,
    FC_WRITE = 2'd2,
    FC_READ  = 2'd3
  } fc_state_t;

  // Keeps the top rb/gb/bb bits of each channel (truncation, no rounding),
  // packed {R, G, B} into the low rb+gb+bb bits of the result.
  function automatic logic [RGB_W-1:0] quantize(input logic [RGB_W-1:0] px,
                                                input int unsigned rb,
                                                input int unsigned gb,
                                                input int unsigned bb);
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
    r = {16'd0, px[23:16]} >> (8 - rb);
    g = {16'd0, px[15:8]}  >> (8 - gb);
    b = {16'd0, px[7:0]}   >> (8 - bb);
    return (r << (gb + bb)) | (g << bb) | b;
  endfunction

endpackage

// File: rtl/frame_capture_buf_if.sv
// Raster, pixel and status bundle between the pixel generator/display mux and
// the frame capture buffer. FRAME_CAPTURE_FRAMECNT_EN adds frame_count/overrun.
interface frame_capture_if #(
  parameter int unsigned PIX_W = 8
);
  import frame_capture_pkg::*;

  logic                store;
  logic                recapture;
  logic [HCOUNT_W-1:0] hcount;
  logic [VCOUNT_W-1:0] vcount;
  logic [HCOUNT_W-1:0] hoffset;
  logic [VCOUNT_W-1:0] voffset;
  logic                in_display;
  logic [RGB_W-1:0]    pixel_in;
  logic [PIX_W-1:0]    dout;
  logic                dout_valid;
  logic                frame_ready;
  logic [1:0]          state;
`ifdef FRAME_CAPTURE_FRAMECNT_EN
  logic [15:0]         frame_count;
  logic                overrun;
`endif

  modport master (
    output store, recapture, hcount, vcount, hoffset, voffset, in_display, pixel_in,
    input  dout, dout_valid, frame_ready, state
`ifdef FRAME_CAPTURE_FRAMECNT_EN
    , input frame_count, overrun
`endif
  );

  modport slave (
    input  store, recapture, hcount, vcount, hoffset, voffset, in_display, pixel_in,
    output dout, dout_valid, frame_ready, state
`ifdef FRAME_CAPTURE_FRAMECNT_EN
    , output frame_count, overrun
`endif
  );

endinterface

// File: rtl/frame_capture_buf_ram.sv
// Single-port DEPTH x PIX_W frame store, registered output, write-first.
// Written in the plain inferred-RAM template so it maps onto block RAM.
module frame_capture_ram #(
  parameter int unsigned DEPTH  = 256000,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  din,
  output logic [PIX_W-1:0]  dout
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout <= '0;
    end else if (en) begin
      if (we) begin
        dout <= din;
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/frame_capture_buf.sv
// Single-frame capture/replay buffer: FSM, write/read counters and store edge
// detect. Optional FRAME_CAPTURE_FRAMECNT_EN adds frame_count and overrun.
module frame_capture_buf
  import frame_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 400,
  parameter int unsigned R_BITS   = 3,
  parameter int unsigned G_BITS   = 3,
  parameter int unsigned B_BITS   = 2
) (
  input  logic          clk,
  input  logic          rst,
  frame_capture_if.slave bus
);

  localparam int unsigned PIX_W  = R_BITS + G_BITS + B_BITS;
  localparam int unsigned DEPTH  = H_ACTIVE * V_ACTIVE;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic              frame_ready_q, frame_ready_d;
  logic              dout_valid_q;
  logic              store_q;
`ifdef FRAME_CAPTURE_FRAMECNT_EN
  logic [15:0]       frame_count_q, frame_count_d;
  logic              overrun_q, overrun_d;
`endif

  logic              at_origin;
  logic              store_rise;
  logic              store_fall;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic              ram_we;
  logic [PIX_W-1:0]  qpix;
  logic [PIX_W-1:0]  ram_dout;

  assign at_origin  = (bus.hcount == bus.hoffset) && (bus.vcount == bus.voffset);
  assign store_rise =  bus.store & ~store_q;
  assign store_fall = ~bus.store &  store_q;
  assign qpix       = PIX_W'(quantize(bus.pixel_in, R_BITS, G_BITS, B_BITS));

  // Origin overrides the read counter combinationally so the origin pixel reads address 0.
  assign raddr = at_origin ? '0 : rcnt_q;

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    rcnt_d        = rcnt_q;
    frame_ready_d = frame_ready_q;
    ram_we        = 1'b0;
    ram_en        = 1'b0;
    ram_addr      = wcnt_q;
`ifdef FRAME_CAPTURE_FRAMECNT_EN
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
`endif

    unique case (state_q)
      FC_IDLE: begin
        wcnt_d = '0;
        rcnt_d = '0;
        if (store_rise) begin
          state_d = FC_ARM;
        end
      end

      FC_ARM: begin
        ram_addr = '0;
        if (store_fall) begin
          state_d = FC_IDLE;
        end else if (at_origin) begin
          state_d = FC_WRITE;
          if (bus.in_display) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
            wcnt_d = ADDR_W'(1);
          end else begin
            wcnt_d = '0;
          end
        end
      end

      FC_WRITE: begin
        if (store_fall) begin
          state_d = FC_IDLE;
`ifdef FRAME_CAPTURE_FRAMECNT_EN
          overrun_d = 1'b1;
`endif
        end else if (bus.in_display) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
          if (wcnt_q == LAST_ADDR) begin
            state_d       = FC_READ;
            frame_ready_d = 1'b1;
`ifdef FRAME_CAPTURE_FRAMECNT_EN
            frame_count_d = frame_count_q + 16'd1;
`endif
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      FC_READ: begin
        ram_en   = 1'b1;
        ram_addr = raddr;
        if (store_fall) begin
          state_d       = FC_IDLE;
          frame_ready_d = 1'b0;
        end else if (bus.recapture) begin
          state_d       = FC_ARM;
          frame_ready_d = 1'b0;
          wcnt_d        = '0;
          rcnt_d        = '0;
        end else if (bus.in_display) begin
          // Advance from the effective address, so the pixel after origin reads 1.
          rcnt_d = (raddr == LAST_ADDR) ? '0 : raddr + 1'b1;
        end else if (at_origin) begin
          rcnt_d = '0;
        end
      end
    endcase

    if (!rst) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= FC_IDLE;
      wcnt_q        <= '0;
      rcnt_q        <= '0;
      frame_ready_q <= 1'b0;
      dout_valid_q  <= 1'b0;
      store_q       <= 1'b0;
`ifdef FRAME_CAPTURE_FRAMECNT_EN
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      rcnt_q        <= rcnt_d;
      frame_ready_q <= frame_ready_d;
      dout_valid_q  <= (state_q == FC_READ) && bus.in_display;
      store_q       <= bus.store;
`ifdef FRAME_CAPTURE_FRAMECNT_EN
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
`endif
    end
  end

  frame_capture_ram #(
    .DEPTH (DEPTH),
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk (clk),
    .rst (rst),
    .en  (ram_en),
    .we  (ram_we),
    .addr(ram_addr),
    .din (qpix),
    .dout(ram_dout)
  );

  assign bus.dout        = ram_dout;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.state       = state_q;
`ifdef FRAME_CAPTURE_FRAMECNT_EN
  assign bus.frame_count = frame_count_q;
  assign bus.overrun     = overrun_q;
`endif

endmodule
